// File: rtl/spi_rx_pingpong_ctrl.sv
// Ping-pong controller for two SPI word buffers: one bank fills from the SPI
// receiver while the other drains to the processor; roles swap once both sides finish.
module spi_rx_pingpong_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 10,
  localparam int CNT_WIDTH = $clog2(BUF_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_valid,
  input  logic [DATA_WIDTH-1:0] spi_data,
  input  logic                  spi_frame_end,
  input  logic                  pu_oe,
  input  logic                  pu_cycle_end,
  output logic [DATA_WIDTH-1:0] pu_data,
  output logic                  pu_data_valid,
  output logic [CNT_WIDTH-1:0]  rx_count,
  output logic [1:0]            buf_rst,
  output logic [1:0]            buf_wr,
  output logic [1:0]            buf_oe,
  output logic [DATA_WIDTH-1:0] buf_data_in,
  input  logic [DATA_WIDTH-1:0] buf0_data_out,
  input  logic [DATA_WIDTH-1:0] buf1_data_out,
  output logic                  bank_sel,
  output logic                  overflow,
  output logic                  underflow
);

  typedef enum logic [1:0] {RUN, WAIT_PU, WAIT_SPI, SWAP} state_e;

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(BUF_SIZE);

  state_e                state_q, state_d;
  logic                  bank_sel_q, bank_sel_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]  rx_cnt_q, rx_cnt_d;
  logic                  pu_valid_q, pu_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      bank_sel_q   <= 1'b0;
      wr_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      pu_valid_q   <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      bank_sel_q   <= bank_sel_d;
      wr_cnt_q     <= wr_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      pu_valid_q   <= pu_valid_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (spi_frame_end && pu_cycle_end) state_d = SWAP;
        else if (spi_frame_end)            state_d = WAIT_PU;
        else if (pu_cycle_end)             state_d = WAIT_SPI;
      end
      WAIT_PU:  if (pu_cycle_end)  state_d = SWAP;
      WAIT_SPI: if (spi_frame_end) state_d = SWAP;
      SWAP:     state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    bank_sel_d   = bank_sel_q;
    wr_cnt_d     = wr_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    pu_valid_d   = 1'b0;
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    buf_rst      = 2'b00;
    buf_wr       = 2'b00;
    buf_oe       = 2'b00;
    buf_data_in  = skid_valid_q ? skid_data_q : spi_data;

    if (state_q == SWAP) begin
      buf_rst      = 2'b11;
      bank_sel_d   = ~bank_sel_q;
      rx_cnt_d     = wr_cnt_q;
      wr_cnt_d     = '0;
      skid_valid_d = spi_valid;
      skid_data_d  = spi_data;
    end else begin
      // A pending skid word goes first; a word arriving alongside it waits one cycle.
      skid_valid_d = skid_valid_q && spi_valid;
      if (skid_valid_q && spi_valid) skid_data_d = spi_data;
      if (skid_valid_q || spi_valid) begin
        if (wr_cnt_q < FULL) begin
          buf_wr   = bank_sel_q ? 2'b10 : 2'b01;
          wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (pu_oe) begin
        if (rx_cnt_q != '0) begin
          buf_oe     = bank_sel_q ? 2'b01 : 2'b10;
          rx_cnt_d   = rx_cnt_q - CNT_WIDTH'(1);
          pu_valid_d = 1'b1;
        end else begin
          udf_d = 1'b1;
        end
      end
    end

    if (rst) begin
      buf_rst = 2'b11;
      buf_wr  = 2'b00;
      buf_oe  = 2'b00;
    end
  end

  assign pu_data       = bank_sel_q ? buf0_data_out : buf1_data_out;
  assign pu_data_valid = pu_valid_q;
  assign rx_count      = rx_cnt_q;
  assign bank_sel      = bank_sel_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule

// File: tb/tb_spi_rx_pingpong_ctrl.sv
// Scoreboard bench for spi_rx_pingpong_ctrl: directed scenarios followed by random
// traffic, checked against a queue-based model of the two banks.
module tb_spi_rx_pingpong_ctrl;
  localparam int DW = 32;
  localparam int BS = 10;
  localparam int CW = $clog2(BS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_valid = 1'b0;
  logic [DW-1:0] spi_data = '0;
  logic          spi_frame_end = 1'b0;
  logic          pu_oe = 1'b0;
  logic          pu_cycle_end = 1'b0;
  logic [DW-1:0] pu_data;
  logic          pu_data_valid;
  logic [CW-1:0] rx_count;
  logic [1:0]    buf_rst, buf_wr, buf_oe;
  logic [DW-1:0] buf_data_in;
  logic [DW-1:0] buf0_data_out, buf1_data_out;
  logic          bank_sel, overflow, underflow;

  spi_rx_pingpong_ctrl #(.DATA_WIDTH(DW), .BUF_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .spi_valid(spi_valid), .spi_data(spi_data),
    .spi_frame_end(spi_frame_end), .pu_oe(pu_oe), .pu_cycle_end(pu_cycle_end),
    .pu_data(pu_data), .pu_data_valid(pu_data_valid), .rx_count(rx_count),
    .buf_rst(buf_rst), .buf_wr(buf_wr), .buf_oe(buf_oe), .buf_data_in(buf_data_in),
    .buf0_data_out(buf0_data_out), .buf1_data_out(buf1_data_out),
    .bank_sel(bank_sel), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Two word buffers sharing one address counter each, read data one cycle after oe.
  logic [DW-1:0] mem [2][BS];
  int            addr [2];
  logic [DW-1:0] dout [2];
  assign buf0_data_out = dout[0];
  assign buf1_data_out = dout[1];

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (buf_rst[b]) begin
        addr[b] <= 0;
      end else if (buf_wr[b]) begin
        if (addr[b] < BS) mem[b][addr[b]] <= buf_data_in;
        addr[b] <= addr[b] + 1;
      end else if (buf_oe[b]) begin
        dout[b] <= (addr[b] < BS) ? mem[b][addr[b]] : '0;
        addr[b] <= addr[b] + 1;
      end
    end
  end

  logic [DW-1:0] writeQ[$], readQ[$], skidQ[$], sbQ[$];
  bit mBank = 1'b0, mOvf = 1'b0, mUdf = 1'b0, mSwap = 1'b0;
  bit frameSeen = 1'b0, cycleSeen = 1'b0;
  int checks = 0, failures = 0;
  bit done = 1'b0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("bank_sel", 32'(bank_sel), 32'(mBank));
    checkVal("rx_count", 32'(rx_count), 32'(readQ.size()));
    checkVal("overflow", 32'(overflow), 32'(mOvf));
    checkVal("underflow", 32'(underflow), 32'(mUdf));
  endtask

  // One clock cycle: check registered state, drive inputs, check strobes, advance model.
  task automatic applyStimulus(input bit rs, input bit sv, input logic [DW-1:0] sd,
                               input bit fe, input bit ce, input bit oe);
    logic [1:0]    expRst, expWr, expOe;
    logic [DW-1:0] expDin, w;
    bit            have;
    @(negedge clk);
    checkOutput();
    rst = rs; spi_valid = sv; spi_data = sd;
    spi_frame_end = fe; pu_cycle_end = ce; pu_oe = oe;
    #1;
    expRst = 2'b00; expWr = 2'b00; expOe = 2'b00; expDin = '0; w = '0; have = 1'b0;
    if (rs) begin
      expRst = 2'b11;
      writeQ.delete(); readQ.delete(); skidQ.delete();
      mBank = 1'b0; mOvf = 1'b0; mUdf = 1'b0; mSwap = 1'b0;
      frameSeen = 1'b0; cycleSeen = 1'b0;
    end else if (mSwap) begin
      expRst = 2'b11;
      readQ = writeQ;
      writeQ.delete();
      mBank = ~mBank;
      if (sv) skidQ.push_back(sd);
      mSwap = 1'b0; frameSeen = 1'b0; cycleSeen = 1'b0;
    end else begin
      if (skidQ.size() > 0) begin
        w = skidQ.pop_front(); have = 1'b1;
        if (sv) skidQ.push_back(sd);
      end else if (sv) begin
        w = sd; have = 1'b1;
      end
      if (have) begin
        if (writeQ.size() < BS) begin
          expWr = mBank ? 2'b10 : 2'b01; expDin = w; writeQ.push_back(w);
        end else begin
          mOvf = 1'b1;
        end
      end
      if (oe) begin
        if (readQ.size() > 0) begin
          expOe = mBank ? 2'b01 : 2'b10; sbQ.push_back(readQ.pop_front());
        end else begin
          mUdf = 1'b1;
        end
      end
      frameSeen |= fe; cycleSeen |= ce;
      if (frameSeen && cycleSeen) begin
        mSwap = 1'b1; frameSeen = 1'b0; cycleSeen = 1'b0;
      end
    end
    checkVal("buf_rst", 32'(buf_rst), 32'(expRst));
    checkVal("buf_wr", 32'(buf_wr), 32'(expWr));
    checkVal("buf_oe", 32'(buf_oe), 32'(expOe));
    if (expWr != 2'b00) checkVal("buf_data_in", buf_data_in, expDin);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0);
  endtask

  task automatic word(input logic [DW-1:0] d);
    applyStimulus(0, 1, d, 0, 0, 0);
    idle(1);
  endtask

  // Every accepted read must be answered by pu_data_valid at the following sample.
  initial begin
    logic [DW-1:0] exp;
    while (!done) begin
      @(negedge clk);
      if (pu_data_valid === 1'b1) begin
        if (sbQ.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL pu_data_valid: got 1 expected 0 at %0t", $time);
        end else begin
          exp = sbQ.pop_front();
          checkVal("pu_data", pu_data, exp);
        end
      end else if (sbQ.size() > 0) begin
        checks++; failures++;
        $display("[TB] FAIL pu_data_valid: got %b expected 1 at %0t", pu_data_valid, $time);
        void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    bit prevSv, sv;
    @(negedge clk);
    applyStimulus(1, 0, '0, 0, 0, 0);

    word(32'hA1); word(32'hA2); word(32'hA3);
    applyStimulus(0, 0, '0, 1, 1, 0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, '0, 0, 0, 1);
      idle(1);
    end

    for (int i = 0; i < 11; i++) word(32'hB0 + 32'(i));
    applyStimulus(0, 0, '0, 1, 0, 0);
    idle(2);
    applyStimulus(0, 0, '0, 0, 1, 0);
    idle(2);

    applyStimulus(0, 0, '0, 0, 1, 0);
    idle(4);
    applyStimulus(0, 0, '0, 1, 0, 0);
    idle(2);

    word(32'hC1);
    applyStimulus(0, 0, '0, 1, 1, 0);
    applyStimulus(0, 1, 32'h55, 0, 0, 0);
    idle(2);

    applyStimulus(1, 0, '0, 0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, '0, 1, 1, 0);
      idle(2);
    end

    applyStimulus(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) word(32'hD0 + 32'(i));
    applyStimulus(0, 0, '0, 1, 0, 0);
    idle(1);
    applyStimulus(1, 0, '0, 0, 0, 0);
    idle(2);

    prevSv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      sv = !prevSv && ($urandom_range(0, 2) == 0);
      applyStimulus($urandom_range(0, 499) == 0, sv, $urandom,
                    $urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 2) == 0);
      prevSv = sv;
    end
    idle(3);
    done = 1'b1;
    @(negedge clk);
    checkVal("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_pingpong_ctrl.md
Name: spi_rx_pingpong_ctrl

Overview:
Sequences two instances of the SPI word buffer as a ping-pong pair between the SPI receiver and the processor unit.
- One bank (write bank) is filled by incoming SPI words.
- The other bank (read bank) is drained by the processor.
- Roles swap only when both the SPI frame and the processor computation cycle have ended.
- The controller drives the buffers' rst/wr/oe strobes, muxes their outputs, and tracks word counts and error flags.

Parameters:
DATA_WIDTH, 32, word width, equal to the buffer DATA_WIDTH.
BUF_SIZE, 10, words per bank, equal to the buffer BUF_SIZE.
(local) CNT_WIDTH = $clog2(BUF_SIZE+1), word-counter width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
spi_valid  in  1  SPI receiver presents a complete word (1-cycle pulse)
spi_data  in  DATA_WIDTH  word from the SPI receiver
spi_frame_end  in  1  chip-select deasserted (1-cycle pulse)
pu_oe  in  1  processor requests the next word from the read bank
pu_cycle_end  in  1  processor finished its computation cycle (1-cycle pulse)
pu_data  out  DATA_WIDTH  data_out of the read bank (muxed)
pu_data_valid  out  1  pu_data holds the word for an accepted pu_oe
rx_count  out  CNT_WIDTH  words remaining in the read bank
buf_rst  out  2  per-bank buffer reset
buf_wr  out  2  per-bank write strobe
buf_oe  out  2  per-bank read strobe
buf_data_in  out  DATA_WIDTH  shared write data to both banks
buf0_data_out  in  DATA_WIDTH  bank 0 data_out
buf1_data_out  in  DATA_WIDTH  bank 1 data_out
bank_sel  out  1  index of the current write bank; the read bank is ~bank_sel
overflow  out  1  sticky: an SPI word was dropped
underflow  out  1  sticky: pu_oe was issued with rx_count == 0

Behaviour:
- Reset:
  - state = RUN, bank_sel = 0, write count = 0, rx_count = 0.
  - pu_data_valid = 0, overflow = 0, underflow = 0, skid empty.
  - buf_rst = 2'b11 while rst is high; buf_wr = buf_oe = 0.
  - Reset mid-frame discards all counts and flags.
- Buffer model: each buffer has one address counter, advanced by either wr or oe. Its read data appears one cycle after oe. rst has priority over wr/oe. A bank is therefore never written and read concurrently.
- States:
  - RUN: waiting for frame end and cycle end.
  - WAIT_PU: frame ended, cycle not yet ended.
  - WAIT_SPI: cycle ended, frame not yet ended.
  - SWAP: one cycle.
- Transitions:
  - RUN -> WAIT_PU on spi_frame_end.
  - RUN -> WAIT_SPI on pu_cycle_end.
  - RUN -> SWAP when both arrive in the same cycle.
  - WAIT_PU -> SWAP on pu_cycle_end.
  - WAIT_SPI -> SWAP on spi_frame_end.
  - SWAP -> RUN unconditionally.
- SPI write:
  - In RUN, WAIT_SPI or WAIT_PU, spi_valid with write count < BUF_SIZE asserts buf_wr[bank_sel] for exactly that cycle, with buf_data_in = spi_data, and increments the write count.
  - If write count == BUF_SIZE, the word is dropped and overflow is set.
- SWAP cycle:
  - buf_rst = 2'b11; bank_sel toggles; rx_count <= write count; write count <= 0.
  - A spi_valid arriving in SWAP is captured in a 1-word skid register, not dropped.
  - In the first RUN cycle the skid word is written to the new write bank (write count becomes 1).
  - A spi_valid in that same cycle is stalled into the skid. The skid holds at most one word; spi_valid pulses are never back-to-back, so it cannot overflow.
- Processor read:
  - pu_oe with rx_count > 0, outside SWAP, asserts buf_oe[~bank_sel] and decrements rx_count.
  - pu_data_valid goes high on the next cycle. pu_data is combinationally muxed from buf(~bank_sel)_data_out.
  - pu_oe with rx_count == 0 is ignored and sets underflow.
  - pu_oe during SWAP is ignored; underflow is not set.
- Flag clearing: overflow and underflow clear only on rst.
- Unconsumed read-bank words are discarded at SWAP.
- Unused bits of buf_wr, buf_oe and buf_rst are held at 0.

Test Plan:
1. Reset, then 3 spi_valid words (0xA1, 0xA2, 0xA3), then spi_frame_end and pu_cycle_end in the same cycle -> SWAP for 1 cycle, bank_sel = 1, rx_count = 3. Three pu_oe return 0xA1, 0xA2, 0xA3, each with pu_data_valid one cycle after its pu_oe. rx_count = 0 afterwards.
2. 11 spi_valid words with BUF_SIZE = 10 -> exactly 10 buf_wr pulses, overflow = 1. After the swap, rx_count = 10.
3. pu_cycle_end first, spi_frame_end 5 cycles later -> state passes through WAIT_SPI. SWAP occurs one cycle after the frame end. bank_sel is unchanged before that.
4. spi_valid coincident with SWAP (data 0x55) -> no buf_wr during SWAP. buf_wr[new bank_sel] with 0x55 in the next cycle; write count = 1.
5. pu_oe with rx_count = 0 -> buf_oe = 0, pu_data_valid = 0, underflow = 1, and the flag stays set through later swaps.
6. rst asserted in WAIT_PU with 4 words written -> on the next cycle: bank_sel = 0, rx_count = 0, flags = 0, buf_rst = 2'b11, state = RUN.
